// File: rtl/calc_req_arbiter_pkg.sv
// calc_req_arbiter_pkg: shared op and FSM state encodings for the calculator request arbiter
package calc_req_arbiter_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/calc_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request after the pointer, wrapping
module rr_arbiter
    import calc_req_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 any_grant
);

    logic [N-1:0] mask;
    logic [N-1:0] hi;
    logic [N-1:0] sel;

    // prefer requests above the pointer, otherwise wrap to the lowest; isolate lowest set bit
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) mask[i] = i > int'(ptr);
        hi        = req & mask;
        sel       = (|hi) ? hi : req;
        grant     = sel & (~sel + N'(1));
        any_grant = |req;
    end

endmodule

// File: rtl/calc_req_arbiter.sv
// calc_req_arbiter: shares one sequential calculator among N_REQ requesters (optional watchdog: CALC_ARB_TIMEOUT_EN)
module calc_req_arbiter
    import calc_req_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [2*N_REQ-1:0]  req_op,
    input  logic [DW*N_REQ-1:0] req_a,
    input  logic [DW*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]       rsp_result,
    output logic                rsp_overflow,
    output logic                rsp_error,
    output logic                rsp_timeout,
    output logic                calc_start,
    output logic [1:0]          calc_op,
    output logic [DW-1:0]       calc_a,
    output logic [DW-1:0]       calc_b,
    input  logic [DW-1:0]       calc_result,
    input  logic                calc_overflow,
    input  logic                calc_done,
    input  logic                calc_error
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("calc_req_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_e           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gi;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] owner;
    logic             any_grant;
    logic             to_hit;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // encode the one-hot grant as an index for operand muxing and the pointer update
    always_comb begin
        gi = '0;
        for (int i = 0; i < N_REQ; i++) if (grant[i]) gi = PW'(i);
    end

`ifdef CALC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    // watchdog counts cycles spent in WAIT, restarting from 0 on each entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt <= '0;
        else        wd_cnt <= (state == ST_WAIT) ? wd_cnt + 1'b1 : '0;
    end

    assign to_hit = (state == ST_WAIT) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    // job FSM: grant and latch, one start pulse, capture first done (or abort), hold response until owner accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= PW'(N_REQ - 1);
            owner        <= '0;
            req_ready    <= '0;
            calc_start   <= 1'b0;
            calc_op      <= '0;
            calc_a       <= '0;
            calc_b       <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            req_ready  <= '0;
            calc_start <= 1'b0;
            case (state)
                ST_IDLE: if (any_grant && !calc_done) begin
                    req_ready  <= grant;
                    owner      <= grant;
                    ptr        <= gi;
                    calc_op    <= req_op[gi*2 +: 2];
                    calc_a     <= req_a[gi*DW +: DW];
                    calc_b     <= req_b[gi*DW +: DW];
                    calc_start <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: if (calc_done || to_hit) begin
                    rsp_valid    <= owner;
                    rsp_result   <= calc_done ? calc_result : '0;
                    rsp_overflow <= calc_done && calc_overflow;
                    rsp_error    <= calc_done ? calc_error : 1'b1;
                    rsp_timeout  <= !calc_done;
                    state        <= ST_RESP;
                end
                ST_RESP: if (|(rsp_ready & rsp_valid)) begin
                    rsp_valid <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
